// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO that buffers ALU results with their opcode and flags.
// Optional sticky carry/overflow tracking is enabled with `define ALU_STICKY_FLAGS_EN.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_result,
  input  logic [3:0]               in_menu,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_result,
  output logic [3:0]               out_menu,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNTW-1:0]          ops_total,
  output logic                     sticky_c,
  output logic                     sticky_v,
  input  logic                     clr_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [13:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [CNTW-1:0] r_ops;
  logic            w_push;
  logic            w_pop;
  logic [13:0]     w_head;

  // Handshake: a transfer happens on a rising edge when valid and ready are both 1.
  // Ready/valid flags depend only on the registered level, never on the other side's input.
  assign full      = (r_level == FULL_LVL);
  assign empty     = (r_level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = r_level;
  assign ops_total = r_ops;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ops    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_ops    <= r_ops + CNTW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; empty masks whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_result, in_menu, in_flags};
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_result = empty ? 6'd0 : w_head[13:8];
  assign out_menu   = empty ? 4'd0 : w_head[7:4];
  assign out_flags  = empty ? 4'd0 : w_head[3:0];

`ifdef ALU_STICKY_FLAGS_EN
  logic r_sticky_c;
  logic r_sticky_v;

  // A setting push takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky_c <= 1'b0;
      r_sticky_v <= 1'b0;
    end else begin
      if (w_push && in_flags[3]) r_sticky_c <= 1'b1;
      else if (clr_sticky)       r_sticky_c <= 1'b0;
      if (w_push && in_flags[2]) r_sticky_v <= 1'b1;
      else if (clr_sticky)       r_sticky_v <= 1'b0;
    end
  end

  assign sticky_c = r_sticky_c;
  assign sticky_v = r_sticky_v;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_sticky;
  assign sticky_c     = 1'b0;
  assign sticky_v     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_result = '0;
  logic [3:0]  in_menu = '0;
  logic [3:0]  in_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_result;
  logic [3:0]  out_menu;
  logic [3:0]  out_flags;
  logic [$clog2(DEPTH):0] level;
  logic        full;
  logic        empty;
  logic [CNTW-1:0] ops_total;
  logic        sticky_c;
  logic        sticky_v;
  logic        clr_sticky = 1'b0;

  alu_result_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_menu(in_menu), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_menu(out_menu), .out_flags(out_flags),
    .level(level), .full(full), .empty(empty), .ops_total(ops_total),
    .sticky_c(sticky_c), .sticky_v(sticky_v), .clr_sticky(clr_sticky)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [13:0] exp_q[$];
  int          m_ops = 0;
  logic        m_sc = 1'b0;
  logic        m_sv = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [13:0] head;
    int sz;
    sz = exp_q.size();
    head = (sz > 0) ? exp_q[0] : 14'd0;
    check_eq("level", 32'(level), 32'(sz));
    check_eq("full", 32'(full), 32'(sz == DEPTH));
    check_eq("empty", 32'(empty), 32'(sz == 0));
    check_eq("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    check_eq("out_valid", 32'(out_valid), 32'(sz != 0));
    check_eq("out_result", 32'(out_result), 32'(head[13:8]));
    check_eq("out_menu", 32'(out_menu), 32'(head[7:4]));
    check_eq("out_flags", 32'(out_flags), 32'(head[3:0]));
    check_eq("ops_total", 32'(ops_total), 32'(m_ops % (1 << CNTW)));
`ifdef ALU_STICKY_FLAGS_EN
    check_eq("sticky_c", 32'(sticky_c), 32'(m_sc));
    check_eq("sticky_v", 32'(sticky_v), 32'(m_sv));
`else
    check_eq("sticky_c", 32'(sticky_c), 32'd0);
    check_eq("sticky_v", 32'(sticky_v), 32'd0);
`endif
  endtask

  // Apply the FIFO rules to the model for the inputs present at this edge.
  task automatic model_step();
    bit push, pop;
    push = in_valid && (exp_q.size() < DEPTH);
    pop  = out_ready && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({in_result, in_menu, in_flags});
      m_ops++;
    end
    if (push && in_flags[3]) m_sc = 1'b1;
    else if (clr_sticky)     m_sc = 1'b0;
    if (push && in_flags[2]) m_sv = 1'b1;
    else if (clr_sticky)     m_sv = 1'b0;
  endtask

  // driver: called at a negedge, applies inputs for one clock and checks after it
  task automatic tick(input logic v, input logic [5:0] res, input logic [3:0] mn,
                      input logic [3:0] fl, input logic rdy, input logic clr);
    in_valid = v; in_result = res; in_menu = mn; in_flags = fl;
    out_ready = rdy; clr_sticky = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_mid_cycle();
    in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    rst = 1'b1;
    #2;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ops", 32'(ops_total), 32'd0);
    check_eq("rst_out_result", 32'(out_result), 32'd0);
    exp_q.delete(); m_ops = 0; m_sc = 1'b0; m_sv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();

    // single push visible one cycle later
    tick(1, 6'h2A, 4'b0000, 4'b1000, 0, 0);
    tick(0, 6'h00, 4'b0000, 4'b0000, 0, 0);
    check_eq("t2_result", 32'(out_result), 32'h2A);
    reset_mid_cycle();

    // fill to full, 5th push held off, then pop+valid while full
    for (int i = 1; i <= 4; i++) tick(1, 6'(i), 4'(i), 4'(i), 0, 0);
    check_eq("t3_full", 32'(full), 32'd1);
    tick(1, 6'h05, 4'h5, 4'h0, 0, 0);
    tick(1, 6'h05, 4'h5, 4'h0, 1, 0);
    check_eq("t5_level", 32'(level), 32'd3);
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick(0, 6'h00, 4'h0, 4'h0, 1, 0);
    check_eq("t3_empty", 32'(empty), 32'd1);

    // level 2 steady-state streaming for 6 cycles
    tick(1, 6'h10, 4'h1, 4'h0, 0, 0);
    tick(1, 6'h11, 4'h2, 4'h1, 0, 0);
    for (int i = 0; i < 6; i++) tick(1, 6'(8'h20 + i), 4'(i), 4'(i), 1, 0);
    check_eq("t4_level", 32'(level), 32'd2);

    // sticky overflow: set, set-wins-over-clear, clear alone
    tick(1, 6'h01, 4'h3, 4'b0100, 1, 0);
    tick(1, 6'h02, 4'h3, 4'b0100, 1, 1);
    tick(0, 6'h00, 4'h0, 4'b0000, 1, 1);
    tick(0, 6'h00, 4'h0, 4'b0000, 1, 0);

    // mid-run reset with three entries stored
    for (int i = 0; i < 3; i++) tick(1, 6'(i + 40), 4'h7, 4'hF, 0, 0);
    check_eq("t1_level_before", 32'(level), 32'd3);
    reset_mid_cycle();

    // counter wrap after 2**CNTW pushes
    for (int i = 0; i < (1 << CNTW); i++) tick(1, 6'($urandom_range(0, 63)), 4'h0, 4'h0, 1, 0);
    check_eq("t7_ops_wrap", 32'(ops_total), 32'd0);

    // randomized traffic with varying pressure on each side
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 150) % 3;
      tick(($urandom_range(0, 3) > bias) ? 1'b1 : 1'b0,
           6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) >= (2 - bias)) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_errors);
    $finish;
  end
endmodule
